dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between requester 0 (core Load/Store path) and requester 1 (DMA/debug port). It grants one access at a time using round-robin, drives the memory's active-low chip-select/write strobes with byte mask, and tracks the fixed memory read latency so read data is returned to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- RD_LAT, 1, cycles from read issue to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, requester 0 / 1
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  store data, already lane-aligned
- mask0 / mask1  in  DATA_W/8  store byte enables
- gnt0 / gnt1  out  1  access accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid this cycle
- rdata0 / rdata1  out  DATA_W  read data; 0 when the matching rvalid is low
- mem_cs  out  1  memory chip select, active-low
- mem_wr  out  1  0 = write, 1 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mask  out  DATA_W/8  write byte mask; 0 on reads
- mem_rdata  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: may grant.
  - RD_WAIT: one read outstanding, no grants.
- Registers: state, lat_cnt (2 bits), owner (requester of the outstanding read), last (requester most recently granted).
- Arbitration, evaluated in IDLE and in the final RD_WAIT cycle:
  - Only one requester active: that requester is granted.
  - Both active: the requester with index != last is granted.
  - Reset value of last is 1, so requester 0 wins the first conflict.
  - last updates to the granted index on every grant.
- Grant cycle: gnt of the winner is high for exactly one cycle. In that same cycle:
  - mem_cs = 0
  - mem_addr = winner's addr
  - mem_wr = !we
  - mem_wdata = we ? wdata : 0
  - mem_mask = we ? mask : 0
- No grant: mem_cs = 1, mem_wr = 1, mem_addr = 0, mem_wdata = 0, mem_mask = 0.
- Store grant: the store completes in the grant cycle. State stays IDLE, so back-to-back stores are granted every cycle.
- Load grant: owner is set to the winner, lat_cnt is set to RD_LAT-1, and the next state is RD_WAIT.
- RD_WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0, this is the final cycle: rvalid[owner] = 1 and rdata[owner] = mem_rdata.
  - In the final cycle, arbitration runs again. A new grant in that cycle is legal and follows the same rules. With no load granted, the next state is IDLE.
  - If RD_LAT == 1, the final cycle is the first RD_WAIT cycle.
- Requesters hold req, we, addr, wdata and mask stable until their gnt. Dropping req before gnt withdraws the request with no side effects.
- A requester never receives rvalid for a store.
- The non-owner's rvalid and rdata stay 0.

## Timing
- Reset values (asynchronous, while rst = 1): state = IDLE, lat_cnt = 0, owner = 0, last = 1; all gnt = 0, all rvalid = 0, all rdata = 0; mem_cs = 1, mem_wr = 1, mem_addr = 0, mem_wdata = 0, mem_mask = 0.
- gnt and all mem_* outputs are combinational from state and requests; no registered delay.
- Store latency: 0 cycles (grant cycle = write cycle).
- Load: issued in cycle T; rvalid in cycle T+RD_LAT.
- Maximum load throughput: one load every RD_LAT cycles. Store throughput: one per cycle.
- A store request arriving during RD_WAIT (before the final cycle) waits; this is the only stall source besides arbitration loss.
- Reset asserted while in RD_WAIT: the outstanding read is discarded, rvalid is never raised for it, and the block is in IDLE on the first edge after reset is released.
- Simultaneous events in the final RD_WAIT cycle: rvalid for the old read and gnt for a new access may be high together, for the same or different requesters.

## Test plan
- Reset check: hold rst = 1 with req0 = req1 = 1. Required: mem_cs = 1, gnt0 = gnt1 = 0, all rvalid = 0. After release, the first cycle grants requester 0.
- Round-robin stores: RD_LAT = 1; both requesters request stores continuously; req0 at addr 0x10, wdata 0xAABBCCDD, mask 4'b1111; req1 at addr 0x20, mask 4'b0011. Required: gnt alternates 0,1,0,1; mem_wr = 0 every cycle; mem_mask follows the granted requester.
- Read latency: RD_LAT = 3; req1 load at 0x40 in cycle T; memory returns 0x12345678. Required: gnt1 in T, mem_cs = 0 and mem_wr = 1 in T, no grant in T+1 and T+2, rvalid1 = 1 with rdata1 = 0x12345678 in T+3, rvalid0 = 0 throughout.
- Overlap: RD_LAT = 2; req0 load at T; req1 store pending from T+1. Required: gnt1 occurs only at T+2, in the same cycle as rvalid0 = 1.
- Reset mid-read: RD_LAT = 4; load at T; rst pulsed at T+2. Required: no rvalid in T+4; state IDLE; the next request is granted normally.
- Withdrawn request: req1 raised while a read is outstanding, then dropped before the final cycle. Required: gnt1 never asserts; last is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-port data memory
// between the core load/store path (0) and the DMA/debug port (1).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] mask0,
  input  logic [DATA_W/8-1:0] mask1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic                mem_cs,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] lat_cnt, lat_cnt_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;
  logic       final_cyc, can_grant, grant, win, win_we;

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // one unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    owner_nxt   = owner;
    last_nxt    = last;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    rdata0      = '0;
    rdata1      = '0;
    mem_cs      = 1'b1;
    mem_wr      = 1'b1;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_mask    = '0;

    final_cyc = (state == RD_WAIT) && (lat_cnt == 2'd0);
    can_grant = (state == IDLE) || final_cyc;
    // On conflict the requester that did not win last time gets the memory.
    win       = (req0 && req1) ? ~last : req1;
    win_we    = win ? we1 : we0;
    // Grants are combinational, so they must be masked while reset is held.
    grant     = !rst && can_grant && (req0 || req1);

    if (final_cyc) begin
      rvalid0 = (owner == 1'b0);
      rvalid1 = (owner == 1'b1);
      rdata0  = (owner == 1'b0) ? mem_rdata : '0;
      rdata1  = (owner == 1'b1) ? mem_rdata : '0;
      state_nxt = IDLE;
    end else if (state == RD_WAIT) begin
      lat_cnt_nxt = lat_cnt - 2'd1;
    end

    if (grant) begin
      gnt0      = (win == 1'b0);
      gnt1      = (win == 1'b1);
      mem_cs    = 1'b0;
      mem_wr    = ~win_we;
      mem_addr  = win ? addr1 : addr0;
      mem_wdata = win_we ? (win ? wdata1 : wdata0) : '0;
      mem_mask  = win_we ? (win ? mask1 : mask0) : '0;
      last_nxt  = win;
      if (!win_we) begin
        state_nxt   = RD_WAIT;
        lat_cnt_nxt = LAT_INIT;
        owner_nxt   = win;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
    end
  end

endmodule
